// File: rtl/complex_mac.sv
// complex_mac: signed fixed-point complex multiply-accumulate.
// Accumulates sum(a*b) over len beats through a two-stage pipeline
// (product register, then wide accumulator). The scaled and saturated
// result is presented on S_r/S_i with a one-cycle out_valid pulse.
module complex_mac #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_r,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_r,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] S_r,
    output logic [DATA_W-1:0] S_i
);

    // Product width, product-sum width, accumulator width (sized so no
    // internal overflow is possible for up to 2^LEN_W-1 terms).
    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 1;
    localparam int AW = SW + LEN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     count;
    logic                 p_valid;
    logic signed [SW-1:0] p_r, p_i;
    logic signed [AW-1:0] acc_r, acc_i;
    logic signed [AW-1:0] acc_r_next, acc_i_next;
    logic [DATA_W-1:0]    s_r_q, s_i_q;

    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [PW-1:0] rr, ii, ri, ir;
    logic signed [SW-1:0] prod_r, prod_i;
    logic                 handshake;
    logic                 last_add;

    // Arithmetic shift right by FRAC_W (toward -inf), then clamp to the
    // signed DATA_W range.
    function automatic logic [DATA_W-1:0] fmt(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        logic [AW-DATA_W:0]   top;
        sh  = acc >>> FRAC_W;
        top = sh[AW-1:DATA_W-1];
        if ((&top) || !(|top))
            return sh[DATA_W-1:0];
        else if (sh[AW-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    // Full-precision complex product of the current operands.
    always_comb begin
        ar_x   = PW'($signed(a_r));
        ai_x   = PW'($signed(a_i));
        br_x   = PW'($signed(b_r));
        bi_x   = PW'($signed(b_i));
        rr     = ar_x * br_x;
        ii     = ai_x * bi_x;
        ri     = ar_x * bi_x;
        ir     = ai_x * br_x;
        prod_r = SW'(rr) - SW'(ii);
        prod_i = SW'(ri) + SW'(ir);
    end

    assign in_ready  = (state == ACC) && (count < len_q);
    assign handshake = in_valid && in_ready;
    // Last product sits in stage 1 and is being folded in on this edge.
    assign last_add  = (state == ACC) && p_valid && (count == len_q);

    // Accumulator value after this edge's stage-2 add.
    always_comb begin
        acc_r_next = acc_r;
        acc_i_next = acc_i;
        if (p_valid) begin
            acc_r_next = acc_r + AW'(p_r);
            acc_i_next = acc_i + AW'(p_i);
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start is only honoured in IDLE.
    // NOTE: state_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : ACC;
            ACC:     if (last_add) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, product stage, accumulation, result formatting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            count   <= '0;
            p_valid <= 1'b0;
            p_r     <= '0;
            p_i     <= '0;
            acc_r   <= '0;
            acc_i   <= '0;
            s_r_q   <= '0;
            s_i_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        count   <= '0;
                        p_valid <= 1'b0;
                        acc_r   <= '0;
                        acc_i   <= '0;
                        s_r_q   <= '0;
                        s_i_q   <= '0;
                    end
                end
                ACC: begin
                    p_valid <= handshake;
                    if (handshake) begin
                        p_r   <= prod_r;
                        p_i   <= prod_i;
                        count <= count + LEN_W'(1);
                    end
                    acc_r <= acc_r_next;
                    acc_i <= acc_i_next;
                    if (last_add) begin
                        s_r_q <= fmt(acc_r_next);
                        s_i_q <= fmt(acc_i_next);
                    end
                end
                DONE:    p_valid <= 1'b0;
                default: p_valid <= 1'b0;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign S_r       = s_r_q;
    assign S_i       = s_i_q;

endmodule
